uart_line_rx: RTL

UART_LINE_RX -- requirements
Module: uart_line_rx

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_line_rx_if.sv | 32 +++
 rtl/uart_line_buf.sv | 23 ++
 rtl/uart_line_rx.sv | 138 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART line receiver.
// Control characters recognised by the line assembler.
package uart_pkg;

   localparam logic [7:0] CHAR_CR = 8'h0D;
   localparam logic [7:0] CHAR_LF = 8'h0A;
   localparam logic [7:0] CHAR_BS = 8'h08;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_DELIVER = 1'b1
   } state_e;

endpackage

// File: rtl/uart_line_rx_if.sv
// Byte-in / line-out handshake bundle for uart_line_rx.
// Width of line_len follows the line buffer depth.
interface uart_line_rx_if #(
   parameter int MAX_LEN = 32
) ();

   localparam int LW = $clog2(MAX_LEN + 1);

   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic [LW-1:0] line_len;
   logic          line_ovf;
   logic          line_tmo;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid,
      input  out_last, line_len, line_ovf, line_tmo
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid,
      output out_last, line_len, line_ovf, line_tmo
   );

endinterface

// File: rtl/uart_line_buf.sv
// Line storage: one synchronous write port, asynchronous read port.
// Contents are deliberately not reset so it maps onto distributed RAM.
module uart_line_buf #(
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_line_rx.sv
// Assembles received bytes into lines closed by LF or idle timeout,
// then streams the stored line out with length and status flags.
module uart_line_rx #(
   parameter int MAX_LEN     = 32,
   parameter int TIMEOUT_CYC = 27000
) (
   input logic           clk,
   input logic           rst_n,
   uart_line_rx_if.slave bus
);

   import uart_pkg::*;

   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int AW = $clog2(MAX_LEN);
   localparam int IW = $clog2(TIMEOUT_CYC + 1);

   state_e        state_q, state_d;
   logic [LW-1:0] cnt_q, cnt_d;
   logic [LW-1:0] rd_q, rd_d;
   logic [LW-1:0] len_q, len_d;
   logic [IW-1:0] idle_q, idle_d;
   logic          ovf_q, ovf_d;
   logic          tmo_q, tmo_d;
   logic          wr_en;
   logic          in_acc;
   logic          out_acc;
   logic          is_last;
   logic [7:0]    rd_byte;

   uart_line_buf #(
      .DEPTH (MAX_LEN)
   ) u_buf (
      .clk   (clk),
      .we    (wr_en),
      .waddr (cnt_q[AW-1:0]),
      .wdata (bus.in_data),
      .raddr (rd_q[AW-1:0]),
      .rdata (rd_byte)
   );

   assign in_acc  = (state_q == ST_COLLECT) && bus.in_valid;
   assign out_acc = (state_q == ST_DELIVER) && bus.out_ready;
   assign is_last = (rd_q == len_q - LW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_COLLECT;
         cnt_q   <= '0;
         rd_q    <= '0;
         len_q   <= '0;
         idle_q  <= '0;
         ovf_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         len_q   <= len_d;
         idle_q  <= idle_d;
         ovf_q   <= ovf_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      len_d   = len_q;
      idle_d  = '0;
      ovf_d   = ovf_q;
      tmo_d   = tmo_q;
      wr_en   = 1'b0;
      unique case (state_q)
         ST_COLLECT: begin
            if (cnt_q != '0) idle_d = idle_q + IW'(1);
            if (in_acc) begin
               idle_d = '0;
               unique case (1'b1)
                  (bus.in_data == CHAR_CR): begin
                  end
                  (bus.in_data == CHAR_BS): begin
                     if (cnt_q != '0) cnt_d = cnt_q - LW'(1);
                  end
                  (bus.in_data == CHAR_LF): begin
                     tmo_d = 1'b0;
                     if (cnt_q != '0) begin
                        len_d   = cnt_q;
                        rd_d    = '0;
                        state_d = ST_DELIVER;
                     end else begin
                        ovf_d = 1'b0;
                     end
                  end
                  default: begin
                     if (cnt_q < LW'(MAX_LEN)) begin
                        wr_en = 1'b1;
                        cnt_d = cnt_q + LW'(1);
                     end else begin
                        ovf_d = 1'b1;
                     end
                  end
               endcase
            end else if (cnt_q != '0 &&
                         idle_q == IW'(TIMEOUT_CYC - 1)) begin
               // Line went quiet: flush what we have.
               idle_d  = '0;
               len_d   = cnt_q;
               rd_d    = '0;
               tmo_d   = 1'b1;
               state_d = ST_DELIVER;
            end
         end
         ST_DELIVER: begin
            if (out_acc) begin
               rd_d = rd_q + LW'(1);
               if (is_last) begin
                  state_d = ST_COLLECT;
                  cnt_d   = '0;
                  rd_d    = '0;
                  ovf_d   = 1'b0;
                  tmo_d   = 1'b0;
               end
            end
         end
      endcase
   end

   assign bus.in_ready  = (state_q == ST_COLLECT);
   assign bus.out_valid = (state_q == ST_DELIVER);
   assign bus.out_data  = bus.out_valid ? rd_byte : 8'h00;
   assign bus.out_last  = bus.out_valid && is_last;
   assign bus.line_len  = len_q;
   assign bus.line_ovf  = ovf_q;
   assign bus.line_tmo  = tmo_q;

endmodule
